// File: rtl/icache_pkg.sv
// Shared types, derived widths and helpers for the fetch-side direct-mapped I-cache.
package icache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned SETS       = 16;
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned BEAT_BITS  = 64;

  localparam int unsigned OFFSET_W   = $clog2(LINE_BYTES);
  localparam int unsigned INDEX_W    = $clog2(SETS);
  localparam int unsigned TAG_W      = ADDR_W - OFFSET_W - INDEX_W;
  localparam int unsigned LINE_BITS  = LINE_BYTES * 8;
  localparam int unsigned BURSTS     = LINE_BITS / BEAT_BITS;
  localparam int unsigned BEAT_CNT_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam int unsigned WORDS      = LINE_BITS / WORD_W;
  localparam int unsigned WORD_SEL_W = OFFSET_W - 2;

  localparam logic [WORD_W-1:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    FILL    = 2'd2,
    INSTALL = 2'd3
  } icache_state_t;

  // Fetch address split into tag / set index / word-in-line / byte.
  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [INDEX_W-1:0]    index;
    logic [WORD_SEL_W-1:0] word;
    logic [1:0]            byte_off;
  } imem_addr_t;

  // Pick one 32-bit word out of a line; word 0 sits in the low bits.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_BITS-1:0]  line,
                                                  input logic [WORD_SEL_W-1:0] sel);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (sel == WORD_SEL_W'(i)) w = line[i*WORD_W +: WORD_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Refill beat assembler: counts incoming beats and packs them into one line register,
// lowest address in the lowest bits.
module icache_line_buf
  import icache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 beat_valid,
  input  logic [BEAT_BITS-1:0] beat_data,
  output logic                 last_beat,
  output logic [LINE_BITS-1:0] line
);

  logic [BEAT_CNT_W-1:0] beat_cnt;

  assign last_beat = beat_valid && (beat_cnt == BEAT_CNT_W'(BURSTS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_cnt <= '0;
    end else if (beat_valid) begin
      beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
    end
  end

  // Data-only storage; contents are don't-care until a full burst has landed.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < BURSTS; b++) begin
      if (beat_valid && (beat_cnt == BEAT_CNT_W'(b))) begin
        line[b*BEAT_BITS +: BEAT_BITS] <= beat_data;
      end
    end
  end

endmodule

// File: rtl/imem_icache_responder.sv
// Blocking, read-only, direct-mapped I-cache answering fetch imem requests; hits are
// combinational, misses refill one line over the burst memory port.
module imem_icache_responder
  import icache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    imem_addr,
  input  logic [3:0]           imem_rmask,
  output logic [WORD_W-1:0]    imem_rdata,
  output logic                 imem_resp,
  input  logic                 inv_all,
  output logic [ADDR_W-1:0]    bmem_addr,
  output logic                 bmem_read,
  input  logic                 bmem_ready,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
);

  icache_state_t state, next_state;

  logic [SETS-1:0]      valid;
  logic [TAG_W-1:0]     tag_arr  [SETS];
  logic [LINE_BITS-1:0] data_arr [SETS];

  logic [TAG_W-1:0]     line_tag;
  logic [INDEX_W-1:0]   line_idx;
  logic                 kill;

  imem_addr_t           fa;
  logic                 req, tag_hit, hit, miss_start, fill_start;
  logic                 beat_valid, last_beat;
  logic [LINE_BITS-1:0] fill_line;
  logic [1:0]           unused_byte_off;

  assign fa              = imem_addr;
  assign unused_byte_off = fa.byte_off;

  assign req        = |imem_rmask;
  assign tag_hit    = valid[fa.index] && (tag_arr[fa.index] == fa.tag);
  assign hit        = (state == IDLE) && req && tag_hit && !inv_all;
  assign miss_start = (state == IDLE) && req && !tag_hit && !inv_all;
  assign fill_start = (state == REQ) && bmem_ready;
  assign beat_valid = (state == FILL) && bmem_rvalid;

  icache_line_buf u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .clear      (fill_start),
    .beat_valid (beat_valid),
    .beat_data  (bmem_rdata),
    .last_beat  (last_beat),
    .line       (fill_line)
  );

  // Same-cycle hit response; NOP whenever nothing valid is returned.
  always_comb begin
    imem_resp  = hit;
    imem_rdata = NOP_INSN;
    if (hit) imem_rdata = line_word(data_arr[fa.index], fa.word);
  end

  always_comb begin
    bmem_read = (state == REQ);
    bmem_addr = '0;
    if (state == REQ) bmem_addr = {line_tag, line_idx, OFFSET_W'(0)};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss_start) next_state = REQ;
      REQ:     if (bmem_ready) next_state = FILL;
      FILL:    if (last_beat)  next_state = INSTALL;
      INSTALL: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_tag <= '0;
      line_idx <= '0;
    end else if (miss_start) begin
      line_tag <= fa.tag;
      line_idx <= fa.index;
    end
  end

  // Remembers an invalidate that arrived while a refill was in flight.
  always_ff @(posedge clk) begin
    if (rst) kill <= 1'b0;
    else     kill <= (next_state != IDLE) && (kill || inv_all);
  end

  always_ff @(posedge clk) begin
    if (rst || inv_all) begin
      valid <= '0;
    end else if (state == INSTALL) begin
      valid[line_idx] <= !kill;
    end
  end

  always_ff @(posedge clk) begin
    if (state == INSTALL) begin
      tag_arr[line_idx]  <= line_tag;
      data_arr[line_idx] <= fill_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (hit)        perf_hits   <= perf_hits + 32'd1;
      if (miss_start) perf_misses <= perf_misses + 32'd1;
    end
  end

endmodule

// File: tb/tb_imem_icache_responder.sv
// Randomized bench for imem_icache_responder against a transaction-level cache model.
module tb_imem_icache_responder;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        inv_all;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;

  always #5 clk = ~clk;

  imem_icache_responder dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .inv_all     (inv_all),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid),
    .perf_hits   (perf_hits),
    .perf_misses (perf_misses)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: which line each set holds, plus expected counters.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_hits;
  logic [31:0] m_misses;
  bit          m_kill;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a - (a % 4);
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic int unsigned set_of(input logic [31:0] a);
    return (a / 32) % 16;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (32 * 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[set_of(a)] && (m_tag[set_of(a)] == tag_of(a));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = '0;
    m_misses = '0;
    m_kill   = 1'b0;
  endtask

  task automatic model_inv();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // Serve one refill as the memory side; -1 disables the optional inv/rst/switch events.
  task automatic refill(input logic [31:0] line, input int ready_dly, input int gap_max,
                        input int inv_beat, input int rst_beat, input int sw_beat,
                        input logic [31:0] sw_addr);
    for (int d = 0; d <= ready_dly; d++) begin
      @(negedge clk);
      bmem_ready  = (d == ready_dly);
      bmem_rvalid = (d < ready_dly) && ($urandom_range(0, 1) == 1);
      bmem_rdata  = {$urandom, $urandom};
      #1;
      check_eq("req_read", 32'(bmem_read), 32'd1);
      check_eq("req_addr", bmem_addr, line);
      check_eq("req_resp", 32'(imem_resp), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      int g;
      g = $urandom_range(0, gap_max);
      for (int i = 0; i < g; i++) begin
        @(negedge clk);
        bmem_ready = 1'b0; bmem_rvalid = 1'b0; inv_all = 1'b0;
        #1;
        check_eq("fill_resp", 32'(imem_resp), 32'd0);
        check_eq("fill_read", 32'(bmem_read), 32'd0);
      end
      @(negedge clk);
      bmem_ready  = 1'b0;
      inv_all     = (k == inv_beat);
      rst         = (k == rst_beat);
      if (k == sw_beat) imem_addr = sw_addr;
      bmem_rvalid = 1'b1;
      bmem_rdata  = {mem_word(line + 32'(8 * k) + 32'd4), mem_word(line + 32'(8 * k))};
      #1;
      check_eq("beat_resp", 32'(imem_resp), 32'd0);
      check_eq("beat_rdata", imem_rdata, NOP_INSN);
      if (k == inv_beat) begin
        model_inv();
        m_kill = 1'b1;
      end
      if (k == rst_beat) begin
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          rst = 1'b0; inv_all = 1'b0; imem_rmask = 4'h0;
          bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
          #1;
          check_eq("rst_resp", 32'(imem_resp), 32'd0);
          check_eq("rst_read", 32'(bmem_read), 32'd0);
          check_eq("rst_baddr", bmem_addr, 32'd0);
          check_eq("rst_hits", perf_hits, 32'd0);
          check_eq("rst_misses", perf_misses, 32'd0);
        end
        model_reset();
        return;
      end
    end
    @(negedge clk);
    bmem_rvalid = 1'b0; inv_all = 1'b0;
    #1;
    check_eq("inst_resp", 32'(imem_resp), 32'd0);
    check_eq("inst_read", 32'(bmem_read), 32'd0);
    check_eq("inst_baddr", bmem_addr, 32'd0);
    m_valid[set_of(line)] = !m_kill;
    m_tag[set_of(line)]   = tag_of(line);
    m_kill = 1'b0;
  endtask

  // One fetch cycle; a predicted miss is followed by the full refill sequence.
  task automatic access(input logic [31:0] a, input logic [3:0] mask, input int ready_dly,
                        input int gap_max, input int inv_beat, input int rst_beat,
                        input int sw_beat, input logic [31:0] sw_addr);
    @(negedge clk);
    imem_addr   = a;
    imem_rmask  = mask;
    inv_all     = 1'b0;
    bmem_ready  = 1'b0;
    bmem_rvalid = ($urandom_range(0, 7) == 0);
    bmem_rdata  = {$urandom, $urandom};
    #1;
    check_eq("perf_hits", perf_hits, m_hits);
    check_eq("perf_misses", perf_misses, m_misses);
    if (mask == 4'h0) begin
      check_eq("idle_resp", 32'(imem_resp), 32'd0);
      check_eq("idle_rdata", imem_rdata, NOP_INSN);
      check_eq("idle_read", 32'(bmem_read), 32'd0);
    end else if (m_hit(a)) begin
      check_eq("hit_resp", 32'(imem_resp), 32'd1);
      check_eq("hit_rdata", imem_rdata, mem_word(a));
      m_hits++;
    end else begin
      check_eq("miss_resp", 32'(imem_resp), 32'd0);
      check_eq("miss_rdata", imem_rdata, NOP_INSN);
      m_misses++;
      refill(a - (a % 32), ready_dly, gap_max, inv_beat, rst_beat, sw_beat, sw_addr);
    end
  endtask

  task automatic acc(input logic [31:0] a);
    access(a, 4'hF, 0, 0, -1, -1, -1, 32'd0);
  endtask

  task automatic idle_inv(input logic [31:0] a);
    @(negedge clk);
    imem_addr = a; imem_rmask = 4'hF; inv_all = 1'b1; bmem_rvalid = 1'b0;
    #1;
    check_eq("inv_resp", 32'(imem_resp), 32'd0);
    check_eq("inv_rdata", imem_rdata, NOP_INSN);
    model_inv();
  endtask

  initial begin
    rst = 1'b1; imem_addr = '0; imem_rmask = '0; inv_all = 1'b0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("reset_resp", 32'(imem_resp), 32'd0);
    check_eq("reset_rdata", imem_rdata, NOP_INSN);
    check_eq("reset_read", 32'(bmem_read), 32'd0);
    check_eq("reset_baddr", bmem_addr, 32'd0);
    check_eq("reset_hits", perf_hits, 32'd0);
    check_eq("reset_misses", perf_misses, 32'd0);
    rst = 1'b0;

    // Cold miss with minimum latency, then a sweep of the installed line.
    acc(32'h6000_0000);
    acc(32'h6000_0000);
    check_eq("t1_misses", perf_misses, 32'd1);
    for (int w = 1; w < 8; w++) acc(32'h6000_0000 + 32'(4 * w));
    @(negedge clk); imem_rmask = 4'h0; #1;
    check_eq("t2_hits", perf_hits, 32'd8);

    // Same-set conflict.
    acc(32'h6000_0200);
    acc(32'h6000_0204);
    acc(32'h6000_0000);
    acc(32'h6000_0200);
    acc(32'h6000_021C);

    // Address switch during fill: old line installs, new one refills afterwards.
    access(32'h6000_0040, 4'hF, 1, 1, -1, -1, 0, 32'h6000_0080);
    acc(32'h6000_0080);
    acc(32'h6000_0084);
    acc(32'h6000_0048);

    // Invalidate during fill and in idle.
    access(32'h6000_0100, 4'hF, 0, 1, 2, -1, -1, 32'd0);
    acc(32'h6000_0100);
    acc(32'h6000_0104);
    idle_inv(32'h6000_0104);
    acc(32'h6000_0108);

    // Reset on the second beat, then a clean refill.
    access(32'h6000_0300, 4'hF, 0, 0, -1, 1, -1, 32'd0);
    acc(32'h6000_0300);
    acc(32'h6000_031C);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, s;
      a = 32'h6000_0000 + 32'($urandom_range(0, 2) * 32'h200) + 32'($urandom_range(0, 7) * 32)
          + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      s = 32'h6000_0000 + 32'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 19) == 0) begin
        idle_inv(a);
      end else begin
        access(a, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, -1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, s);
      end
    end
    @(negedge clk); imem_rmask = 4'h0; inv_all = 1'b0; bmem_rvalid = 1'b0; #1;
    check_eq("end_hits", perf_hits, m_hits);
    check_eq("end_misses", perf_misses, m_misses);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
